// File: rtl/tts_pkg.sv
// tts_pkg: shared types and constants for the truth-table scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, code width/count, bit positions of f/g/h inside fgh_in.
package tts_pkg;

  localparam int CODE_W = 4;
  localparam int NCODES = 16;

  // Bit positions of the three function outputs inside fgh_in = {f,g,h}.
  localparam int F_IDX = 2;
  localparam int G_IDX = 1;
  localparam int H_IDX = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tts_state_t;

endpackage

// File: rtl/tts_capture.sv
// tts_capture: three 16-bit truth-table registers, one bit per code, written by the scanner FSM.
// Latency: a write lands on the same edge that i_we is sampled high.
// Backpressure: none; i_clr wins over i_we.
// Ports: clk/rst (sync, active-high); i_clr wipes all tables; i_we/i_idx/i_fgh write one column;
//   o_tt_f/o_tt_g/o_tt_h expose the tables.
module tts_capture
  import tts_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [CODE_W-1:0] i_idx,
  input  logic [2:0]        i_fgh,
  output logic [NCODES-1:0] o_tt_f,
  output logic [NCODES-1:0] o_tt_g,
  output logic [NCODES-1:0] o_tt_h
);

  logic [NCODES-1:0] r_tt_f;
  logic [NCODES-1:0] r_tt_g;
  logic [NCODES-1:0] r_tt_h;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_tt_f <= '0;
      r_tt_g <= '0;
      r_tt_h <= '0;
    end else if (i_we) begin
      r_tt_f[i_idx] <= i_fgh[F_IDX];
      r_tt_g[i_idx] <= i_fgh[G_IDX];
      r_tt_h[i_idx] <= i_fgh[H_IDX];
    end
  end

  assign o_tt_f = r_tt_f;
  assign o_tt_g = r_tt_g;
  assign o_tt_h = r_tt_h;

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps code_out through [lo,hi] with en_out high, holds each code SETTLE
//   extra cycles, then captures fgh_in into tt_f/tt_g/tt_h at bit index code_out.
// Latency: N*(SETTLE+1) DRIVE cycles after the start edge (N=hi-lo+1); done pulses the next cycle.
// Backpressure: none; start is honoured only in IDLE, lo/hi are latched at start.
// Ports: clk, rst (sync, active-high); start/lo/hi scan request; fgh_in = {f,g,h} from the
//   function block; code_out/en_out drive the decoder; busy/done/err status; tt_* captured tables.
// Optional: DECODE_SELFCHECK_EN adds dec_in[15:0]; at each capture the decoder lines must equal
//   the one-hot of code_out, otherwise err is set (sticky until next start or reset).
module truth_table_scanner
  import tts_pkg::*;
#(
  parameter int unsigned SETTLE = 0,
  parameter int unsigned SW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] lo,
  input  logic [CODE_W-1:0] hi,
  input  logic [2:0]        fgh_in,
`ifdef DECODE_SELFCHECK_EN
  input  logic [NCODES-1:0] dec_in,
`endif
  output logic [CODE_W-1:0] code_out,
  output logic              en_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NCODES-1:0] tt_f,
  output logic [NCODES-1:0] tt_g,
  output logic [NCODES-1:0] tt_h
);

  tts_state_t        r_state;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_hi;
  logic [SW-1:0]     r_cnt;
  logic              r_en;
  logic              r_err;

  tts_state_t        w_state_nxt;
  logic [CODE_W-1:0] w_code_nxt;
  logic [CODE_W-1:0] w_hi_nxt;
  logic [SW-1:0]     w_cnt_nxt;
  logic              w_en_nxt;
  logic              w_err_nxt;
  logic              w_clr;
  logic              w_we;
  logic              w_settled;
  logic              w_dec_bad;

  assign w_settled = (r_cnt == SW'(SETTLE));

`ifdef DECODE_SELFCHECK_EN
  logic [NCODES-1:0] w_dec_exp;
  assign w_dec_exp = {{(NCODES-1){1'b0}}, 1'b1} << r_code;
  assign w_dec_bad = (dec_in != w_dec_exp);
`else
  assign w_dec_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_hi    <= w_hi_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_hi_nxt    = r_hi;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    w_err_nxt   = r_err;
    w_clr       = 1'b0;
    w_we        = 1'b0;

    case (r_state)
      IDLE: begin
        w_en_nxt = 1'b0;
        if (start) begin
          w_hi_nxt  = hi;
          w_clr     = 1'b1;
          w_err_nxt = 1'b0;
          if (lo > hi) begin
            // Empty range: report it without ever enabling the decoder.
            w_err_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_code_nxt  = lo;
            w_en_nxt    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = DRIVE;
          end
        end
      end

      DRIVE: begin
        if (w_settled) begin
          w_we = 1'b1;
          if (w_dec_bad) begin
            w_err_nxt = 1'b1;
          end
          // Stop on equality so hi=15 never wraps code_out back to 0.
          if (r_code == r_hi) begin
            w_en_nxt    = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_code_nxt = r_code + CODE_W'(1);
            w_cnt_nxt  = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + SW'(1);
        end
      end

      DONE: begin
        w_en_nxt    = 1'b0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_en_nxt    = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  tts_capture u_capture (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_we   (w_we),
    .i_idx  (r_code),
    .i_fgh  (fgh_in),
    .o_tt_f (tt_f),
    .o_tt_g (tt_g),
    .o_tt_h (tt_h)
  );

  assign code_out = r_code;
  assign en_out   = r_en;
  assign busy     = (r_state == DRIVE);
  assign done     = (r_state == DONE);
  assign err      = r_err;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: two scanners (SETTLE=0 and SETTLE=2) driving a model of the
//   f/g/h function block; expected tables, done cycle and code sequence come from a scoreboard.
// Latency/backpressure: n/a (bench).
module tb_truth_table_scanner;

  function automatic logic [2:0] fgh_of(input logic [3:0] c);
    logic f, g, h;
    f = c inside {4'd3, 4'd6, 4'd7, 4'd10, 4'd11, 4'd14};
    g = c inside {4'd2, 4'd3, 4'd10, 4'd14};
    h = c inside {4'd0, 4'd1, 4'd3, 4'd7, 4'd14, 4'd15};
    return {f, g, h};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start2, bad_dec;
  logic [3:0]  lo, hi;
  logic [3:0]  code0, code2;
  logic        en0, en2, busy0, busy2, done0, done2, err0, err2;
  logic [15:0] ttf0, ttg0, tth0, ttf2, ttg2, tth2;
  logic [2:0]  fgh0, fgh2;

  assign fgh0 = en0 ? fgh_of(code0) : 3'b000;
  assign fgh2 = en2 ? fgh_of(code2) : 3'b000;

`ifdef DECODE_SELFCHECK_EN
  logic [15:0] dec0, dec2, one_hot0, one_hot2;
  assign one_hot0 = 16'h0001 << code0;
  assign one_hot2 = 16'h0001 << code2;
  assign dec0 = !en0 ? 16'h0000 : ((bad_dec && code0 == 4'd4) ? 16'h0001 : one_hot0);
  assign dec2 = !en2 ? 16'h0000 : one_hot2;
`endif

  truth_table_scanner #(.SETTLE(0), .SW(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .lo(lo), .hi(hi), .fgh_in(fgh0),
`ifdef DECODE_SELFCHECK_EN
    .dec_in(dec0),
`endif
    .code_out(code0), .en_out(en0), .busy(busy0), .done(done0), .err(err0),
    .tt_f(ttf0), .tt_g(ttg0), .tt_h(tth0)
  );

  truth_table_scanner #(.SETTLE(2), .SW(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .lo(lo), .hi(hi), .fgh_in(fgh2),
`ifdef DECODE_SELFCHECK_EN
    .dec_in(dec2),
`endif
    .code_out(code2), .en_out(en2), .busy(busy2), .done(done2), .err(err2),
    .tt_f(ttf2), .tt_g(ttg2), .tt_h(tth2)
  );

  // sel chooses which scanner the scenario observes: 0 -> SETTLE=0, 1 -> SETTLE=2.
  int          sel;
  logic [3:0]  m_code;
  logic        m_en, m_busy, m_done, m_err;
  logic [15:0] m_f, m_g, m_h;

  always_comb begin
    if (sel == 0) begin
      m_code = code0; m_en = en0; m_busy = busy0; m_done = done0; m_err = err0;
      m_f = ttf0; m_g = ttg0; m_h = tth0;
    end else begin
      m_code = code2; m_en = en2; m_busy = busy2; m_done = done2; m_err = err2;
      m_f = ttf2; m_g = ttg2; m_h = tth2;
    end
  end

  typedef struct {
    logic [15:0] f;
    logic [15:0] g;
    logic [15:0] h;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] code_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Drive one start pulse and push the model's expected result and code sequence.
  task automatic start_scan(input int s, input logic [3:0] l, input logic [3:0] h, input bit bad);
    exp_t       e;
    logic [2:0] v;
    int         settle;
    settle = (s == 0) ? 0 : 2;
    e.f = '0; e.g = '0; e.h = '0;
    e.err = (l > h);
    e.done_cyc = 1;
    if (!(l > h)) begin
      for (int k = int'(l); k <= int'(h); k++) begin
        v = fgh_of(4'(k));
        e.f[k] = v[2];
        e.g[k] = v[1];
        e.h[k] = v[0];
        if (bad && k == 4) e.err = 1'b1;
        for (int r = 0; r <= settle; r++) code_q.push_back(4'(k));
      end
      e.done_cyc = (int'(h) - int'(l) + 1) * (settle + 1) + 1;
    end
    exp_q.push_back(e);
    sel = s;
    @(negedge clk);
    lo = l;
    hi = h;
    if (s == 0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  // Follow the scan cycle by cycle after the start edge; optionally re-pulse start (with a
  // different range) at cycle repulse_at to show it is ignored.
  task automatic collect_scan(input int repulse_at, output int done_cyc);
    logic [3:0] exp_code;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == repulse_at) begin
        lo = 4'd0;
        hi = 4'd15;
        if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
      end else begin
        start0 = 1'b0;
        start2 = 1'b0;
      end
      if (m_done) begin
        done_cyc = cyc;
        n_checks++;
        if (m_en !== 1'b0 || m_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL done_cycle_status: en_out=%b busy=%b, required 0/0", m_en, m_busy);
        end
        break;
      end
      n_checks++;
      if (!m_busy) begin
        n_fail++;
        $display("FAIL drive_busy: cycle %0d busy=%b before done, required 1", cyc, m_busy);
      end else if (code_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_drive: cycle %0d drives code %0d beyond expected sequence", cyc, m_code);
      end else begin
        exp_code = code_q.pop_front();
        if (m_code !== exp_code || m_en !== 1'b1) begin
          n_fail++;
          $display("FAIL drive_code: cycle %0d code_out=%0d en_out=%b, required %0d/1",
                   cyc, m_code, m_en, exp_code);
        end
      end
    end
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    n_checks++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL done_timeout: no done within 200 cycles");
    end
    n_checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_en !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: done=%b busy=%b en_out=%b, required 0/0/0", m_done, m_busy, m_en);
    end
    n_checks++;
    if (code_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_drive: %0d expected drive cycles never seen", code_q.size());
    end
    code_q.delete();
  endtask

  // Pop the scoreboard entry for the scan just collected and compare results.
  task automatic check_result(input string name, input int done_cyc);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: no expected entry", name);
      return;
    end
    e = exp_q.pop_front();
    if (done_cyc != e.done_cyc) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got %0d, required %0d", name, done_cyc, e.done_cyc);
    end
    n_checks++;
    if (m_f !== e.f || m_g !== e.g || m_h !== e.h) begin
      n_fail++;
      $display("FAIL %s_tables: got f=%h g=%h h=%h, required f=%h g=%h h=%h",
               name, m_f, m_g, m_h, e.f, e.g, e.h);
    end
    n_checks++;
    if (m_err !== e.err) begin
      n_fail++;
      $display("FAIL %s_err: got %b, required %b", name, m_err, e.err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (m_code !== 4'd0 || m_en !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: code=%h en=%b busy=%b done=%b err=%b, required all 0",
                 s, m_code, m_en, m_busy, m_done, m_err);
      end
      n_checks++;
      if (m_f !== 16'h0 || m_g !== 16'h0 || m_h !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_tables[%0d]: f=%h g=%h h=%h, required 0", s, m_f, m_g, m_h);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_full_sweep();
    int dc;
    start_scan(0, 4'd0, 4'd15, 1'b0);
    collect_scan(-1, dc);
    check_result("full_sweep", dc);
    n_checks++;
    if (m_f !== 16'h4CC8 || m_g !== 16'h440C || m_h !== 16'hC08B) begin
      n_fail++;
      $display("FAIL full_sweep_const: f=%h g=%h h=%h, required 4cc8/440c/c08b", m_f, m_g, m_h);
    end
  endtask

  task automatic test_subrange_settle();
    int dc;
    start_scan(1, 4'd5, 4'd7, 1'b0);
    collect_scan(-1, dc);
    check_result("subrange", dc);
    n_checks++;
    if (m_f !== 16'h00C0 || m_g !== 16'h0000 || m_h !== 16'h0080) begin
      n_fail++;
      $display("FAIL subrange_const: f=%h g=%h h=%h, required 00c0/0000/0080", m_f, m_g, m_h);
    end
  endtask

  task automatic test_range_error();
    int dc;
    start_scan(0, 4'd9, 4'd3, 1'b0);
    collect_scan(-1, dc);
    check_result("range_err", dc);
  endtask

  task automatic test_single_top();
    int dc;
    start_scan(0, 4'd15, 4'd15, 1'b0);
    collect_scan(-1, dc);
    check_result("single_top", dc);
    n_checks++;
    if (m_code !== 4'd15) begin
      n_fail++;
      $display("FAIL single_top_hold: code_out=%0d in IDLE, required 15", m_code);
    end
  endtask

  task automatic test_restart_ignored();
    int dc;
    start_scan(1, 4'd5, 4'd7, 1'b0);
    collect_scan(4, dc);
    check_result("restart_mid", dc);
    start_scan(0, 4'd2, 4'd3, 1'b0);
    collect_scan(3, dc);
    check_result("restart_done", dc);
  endtask

  task automatic test_mid_reset();
    start_scan(0, 4'd0, 4'd15, 1'b0);
    void'(exp_q.pop_back());
    code_q.delete();
    for (int cyc = 1; cyc <= 6; cyc++) @(negedge clk);
    n_checks++;
    if (m_busy !== 1'b1 || m_code !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_reset_pre: busy=%b code_out=%0d, required 1/5", m_busy, m_code);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_code !== 4'd0 || m_en !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_err !== 1'b0 ||
        m_f !== 16'h0 || m_g !== 16'h0 || m_h !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: code=%h en=%b busy=%b done=%b err=%b f=%h g=%h h=%h, required all 0",
               m_code, m_en, m_busy, m_done, m_err, m_f, m_g, m_h);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: busy=%b done=%b after reset release, required 0/0", m_busy, m_done);
    end
  endtask

`ifdef DECODE_SELFCHECK_EN
  task automatic test_selfcheck();
    int dc;
    bad_dec = 1'b1;
    start_scan(0, 4'd0, 4'd15, 1'b1);
    collect_scan(-1, dc);
    check_result("selfcheck_bad", dc);
    bad_dec = 1'b0;
    start_scan(0, 4'd0, 4'd15, 1'b0);
    collect_scan(-1, dc);
    check_result("selfcheck_good", dc);
  endtask
`endif

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; bad_dec = 1'b0;
    lo = 4'd0; hi = 4'd0; sel = 0;
    test_reset();
    test_full_sweep();
    test_subrange_settle();
    test_range_error();
    test_single_top();
    test_restart_ignored();
    test_mid_reset();
`ifdef DECODE_SELFCHECK_EN
    test_selfcheck();
`endif
    test_full_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus-and-capture stage that sits directly upstream of the team's 4-to-16 decoder-based function block (inputs i[3:0] and En, outputs f/g/h).
- On start, drives each 4-bit code in a programmable range onto the decoder input with enable asserted, waits a settle interval, then samples the 3 function outputs.
- Assembles three 16-bit truth-table words, one per function, for readout by the lab board or a later checker stage.

Parameters:
- SETTLE, 0, extra cycles code_out/en_out are held before fgh_in is sampled (0..15).
- SW, 4, width of the internal settle counter; must hold SETTLE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- lo  input  4  first code of the range; captured at start.
- hi  input  4  last code of the range, inclusive; captured at start.
- fgh_in  input  3  {f,g,h} from the downstream function block, combinational from code_out/en_out.
- code_out  output  4  registered code driving decoder i[3:0].
- en_out  output  1  registered enable driving decoder En.
- busy  output  1  high from the first DRIVE cycle until done.
- done  output  1  one-cycle pulse at scan end.
- err  output  1  range error flag (plus self-check, see feature).
- tt_f  output  16  bit k = sampled f for code k.
- tt_g  output  16  bit k = sampled g for code k.
- tt_h  output  16  bit k = sampled h for code k.

Behaviour:
- Reset (rst=1 at a clk edge) sets: state IDLE; code_out=0; en_out=0; busy=0; done=0; err=0; tt_f/tt_g/tt_h=0; settle counter=0.
- Reset has priority over every event and aborts a scan in progress; no partial result survives.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - en_out=0, busy=0.
  - On start=1: latch lo/hi, clear all three tables, clear err.
  - If lo>hi: go to DONE with err=1; no code is driven.
  - Otherwise: code_out=lo, en_out=1, settle counter=0, go to DRIVE.
- DRIVE:
  - en_out=1, busy=1.
  - While settle counter < SETTLE, increment the counter.
  - When counter == SETTLE, capture fgh_in[2] into tt_f[code_out], fgh_in[1] into tt_g[code_out], fgh_in[0] into tt_h[code_out] on that edge.
  - After the capture: if code_out==hi, go to DONE with en_out=0. Otherwise increment code_out, reset the counter, and stay in DRIVE.
- DONE: done=1 for exactly one cycle, busy=0, en_out=0; return to IDLE. Tables and err hold until the next start or reset.
- Timing: with N=hi-lo+1, the scan occupies N*(SETTLE+1) DRIVE cycles, and done is high on the cycle immediately after the last DRIVE cycle.
- hi=15: the range terminates on the equality compare; code_out never wraps to 0, and no code outside [lo,hi] is ever driven.
- lo==hi: a single code is driven and captured.
- Table bits outside [lo,hi] read 0.
- start asserted while not in IDLE is ignored, including in the DONE cycle.
- lo/hi changing mid-scan has no effect.
- code_out holds its last value in IDLE; en_out=0 there, so the decoder outputs are all-zero.

Optional Feature:
- Macro DECODE_SELFCHECK_EN.
- When defined, adds input dec_in[15:0], the decoder's one-hot output lines.
- At each capture edge, if dec_in != (16'h1 << code_out), set err=1 (sticky until next start or reset).
- In IDLE, dec_in != 0 is ignored.
- When not defined: no dec_in port, and err reflects only lo>hi.

Decomposition:
- Package tts_pkg holds:
  - the state enum {IDLE, DRIVE, DONE};
  - CODE_W=4 and NCODES=16;
  - the fgh bit-index constants F_IDX=2, G_IDX=1, H_IDX=0.
- Sub-module tts_capture holds the three 16-bit tables, with write-enable and index from the FSM.
- The FSM, code counter and settle counter stay in truth_table_scanner.

Test Plan:
- Full sweep:
  - Stimulus: SETTLE=0, lo=0, hi=15, downstream block with f=Σm(3,6,7,10,11,14), g=Σm(2,3,10,14), h=Σm(0,1,3,7,14,15); start pulsed 1 cycle.
  - Response: tt_f=16'h4CC8, tt_g=16'h440C, tt_h=16'hC08B; done pulses 17 cycles after the start edge; err=0.
- Sub-range with settle:
  - Stimulus: SETTLE=2, lo=5, hi=7.
  - Response: 9 DRIVE cycles with code_out stepping 5→6→7 every 3 cycles; tt_f=16'h00C0, tt_g=16'h0000, tt_h=16'h0080.
- Error and edge cases:
  - lo=9, hi=3: done one cycle later, err=1, tables 0, en_out never high.
  - lo=hi=15: one capture; code_out stays 15 and does not wrap.
- Mid-scan events:
  - rst at the 6th DRIVE cycle: next cycle all outputs 0, state IDLE.
  - start re-pulsed mid-scan: no effect on the sequence.
- DECODE_SELFCHECK_EN: force dec_in=16'h0001 while code_out=4 → err=1 after done; with a correct dec_in, err stays 0.
